// File: rtl/fp_divide.sv
// Sequential single-precision divider: op1 / op2.
// Restoring mantissa divider (one quotient bit per clock), truncation rounding,
// denormal inputs flushed to zero, exponent 255 treated as an ordinary finite value.
module fp_divide #(
  parameter int unsigned BIAS = 127
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        div_start,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] div_result,
  output logic        div_done,
  output logic        div_overflow,
  output logic        div_busy
);

  typedef enum logic [1:0] {StIdle, StDivide, StNorm, StDone} state_e;

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  ediff_q, ediff_d;
  logic [24:0]        rem_q, rem_d;
  logic [23:0]        dvsr_q, dvsr_d;
  logic [24:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  // A special-case hit is resolved at the start edge and retired one edge later,
  // so that the outputs only change on entry to StDone.
  logic               spec_q, spec_d;
  logic [31:0]        spec_res_q, spec_res_d;
  logic               spec_ovf_q, spec_ovf_d;
  logic [31:0]        result_q, result_d;
  logic               ovf_q, ovf_d;

  logic [7:0]         e1, e2;
  logic               sign_new;
  logic signed [9:0]  ediff_new;
  logic               spec_hit;
  logic [31:0]        spec_res;
  logic               spec_ovf;
  logic [24:0]        dvsr_ext;
  logic [24:0]        rem_diff;
  logic               rem_ge;
  logic signed [9:0]  exp_n;
  logic [22:0]        frac_n;

  assign e1        = op1[30:23];
  assign e2        = op2[30:23];
  assign sign_new  = op1[31] ^ op2[31];
  // Modulo-1024 arithmetic gives the correct two's complement result in 10 bits.
  assign ediff_new = $signed({2'b00, e1} - {2'b00, e2} + 10'(BIAS));

  assign dvsr_ext  = {1'b0, dvsr_q};
  assign rem_ge    = (rem_q >= dvsr_ext);
  assign rem_diff  = rem_q - dvsr_ext;

  // Normalise: quotient lies in (0.5, 2), so at most one bit of left shift.
  assign exp_n     = quo_q[24] ? ediff_q : ediff_q - 10'sd1;
  assign frac_n    = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

  assign div_result   = result_q;
  assign div_overflow = ovf_q;
  assign div_done     = (state_q == StDone);
  assign div_busy     = (state_q != StIdle);

  // Zero-exponent operand detection and the result each case produces.
  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    spec_ovf = 1'b0;
    if (e1 == 8'd0 && e2 == 8'd0) begin
      spec_res = 32'h7FC0_0000;
      spec_ovf = 1'b1;
    end else if (e2 == 8'd0) begin
      spec_res = {sign_new, 8'hFF, 23'h0};
      spec_ovf = 1'b1;
    end else if (e1 == 8'd0) begin
      spec_res = {sign_new, 31'h0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // FSM next-state and datapath next-values.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    ediff_d    = ediff_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_ovf_d = spec_ovf_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (div_start) begin
          sign_d     = sign_new;
          ediff_d    = ediff_new;
          rem_d      = {2'b01, op1[22:0]};
          dvsr_d     = {1'b1, op2[22:0]};
          quo_d      = '0;
          cnt_d      = '0;
          spec_d     = spec_hit;
          spec_res_d = spec_res;
          spec_ovf_d = spec_ovf;
          state_d    = StDivide;
        end
      end
      StDivide: begin
        if (spec_q) begin
          result_d = spec_res_q;
          ovf_d    = spec_ovf_q;
          state_d  = StDone;
        end else begin
          // R < 2D always holds, so the shifted remainder fits in 25 bits.
          rem_d = rem_ge ? {rem_diff[23:0], 1'b0} : {rem_q[23:0], 1'b0};
          quo_d = {quo_q[23:0], rem_ge};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd24) begin
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
        if (exp_n >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'h0};
          ovf_d    = 1'b1;
        end else if (exp_n <= 10'sd0) begin
          result_d = {sign_q, 31'h0};
          ovf_d    = 1'b0;
        end else begin
          result_d = {sign_q, exp_n[7:0], frac_n};
          ovf_d    = 1'b0;
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      sign_q     <= 1'b0;
      ediff_q    <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_ovf_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      ediff_q    <= ediff_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_ovf_q <= spec_ovf_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
